// File: rtl/muldiv_pkg.sv
// Shared encodings and default latencies for the multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MULT = 2'b00,
        DIV  = 2'b01,
        DIVM = 2'b10
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_A,
        FETCH_B,
        START,
        RUN,
        WRITE,
        DONE,
        EXC
    } state_e;

    localparam int unsigned DEF_MULT_CYCLES = 32;
    localparam int unsigned DEF_DIV_CYCLES  = 32;
    localparam int unsigned DEF_MEM_LAT     = 2;
    localparam int unsigned DEF_CNT_W       = 6;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Control-unit / datapath handshake and mux-control bundle of the mult/div sequencer.
interface muldiv_sequencer_if;

    logic       start;
    logic [1:0] op;
    logic       div_by_zero;
    logic       busy;
    logic       mem_rd;
    logic       mem_addr_sel;
    logic       aux_a_write;
    logic       aux_b_write;
    logic       mem_a_sel;
    logic       mem_b_sel;
    logic       mult_op;
    logic       div_op;
    logic       mult_div_sel;
    logic       hilo_write;
    logic       done;
    logic       exc_div0;

    modport master (
        output start, op, div_by_zero,
        input  busy, mem_rd, mem_addr_sel, aux_a_write, aux_b_write,
               mem_a_sel, mem_b_sel, mult_op, div_op, mult_div_sel,
               hilo_write, done, exc_div0
    );

    modport slave (
        input  start, op, div_by_zero,
        output busy, mem_rd, mem_addr_sel, aux_a_write, aux_b_write,
               mem_a_sel, mem_b_sel, mult_op, div_op, mult_div_sel,
               hilo_write, done, exc_div0
    );

endinterface

// File: rtl/muldiv_sequencer_cycle_counter.sv
// Loadable down-counter that saturates at zero; shared by memory-wait and RUN timing.
module cycle_counter #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle sequencer for the mult/div units and HI/LO write; all outputs are Moore.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int unsigned MEM_LAT     = DEF_MEM_LAT,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    muldiv_sequencer_if.slave   bus
);

    localparam logic [CNT_W-1:0] W_MEM_RELOAD  = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] W_MULT_RELOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] W_DIV_RELOAD  = CNT_W'(DIV_CYCLES - 1);

    state_e           r_state;
    state_e           w_next;
    op_e              r_op_q;
    logic             w_load;
    logic             w_dec;
    logic [CNT_W-1:0] w_load_val;
    logic [CNT_W-1:0] w_count;
    logic             w_zero;
    logic             w_accept;
    logic             w_aux_sel;

    // op=11 is never accepted, so it neither leaves IDLE nor disturbs op_q
    assign w_accept = (r_state == IDLE) && bus.start && (bus.op != 2'b11);

    cycle_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst_n      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_count    (w_count),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_op_q  <= MULT;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op_q <= op_e'(bus.op);
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_dec      = 1'b0;
        w_load_val = W_MEM_RELOAD;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (bus.op == DIVM) begin
                        w_next = FETCH_A;
                        w_load = 1'b1;
                    end else begin
                        w_next = START;
                    end
                end
            end
            FETCH_A: begin
                if (w_zero) begin
                    w_next = FETCH_B;
                    w_load = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            FETCH_B: begin
                if (w_zero) w_next = START;
                else        w_dec  = 1'b1;
            end
            START: begin
                w_load     = 1'b1;
                w_load_val = (r_op_q == MULT) ? W_MULT_RELOAD : W_DIV_RELOAD;
                w_next     = RUN;
            end
            RUN: begin
                // divide-by-zero wins over normal completion in the same cycle
                if ((r_op_q != MULT) && bus.div_by_zero) w_next = EXC;
                else if (w_zero)                         w_next = WRITE;
                else                                     w_dec  = 1'b1;
            end
            WRITE:   w_next = DONE;
            DONE:    w_next = IDLE;
            EXC:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_aux_sel = (r_op_q == DIVM) &&
                       ((r_state == START) || (r_state == RUN) || (r_state == WRITE));

    assign bus.busy         = (r_state != IDLE);
    assign bus.mem_rd       = (r_state == FETCH_A) || (r_state == FETCH_B);
    assign bus.mem_addr_sel = (r_state == FETCH_B);
    assign bus.aux_a_write  = (r_state == FETCH_A) && w_zero;
    assign bus.aux_b_write  = (r_state == FETCH_B) && w_zero;
    assign bus.mem_a_sel    = w_aux_sel;
    assign bus.mem_b_sel    = w_aux_sel;
    assign bus.mult_op      = (r_state == START) && (r_op_q == MULT);
    assign bus.div_op       = (r_state == START) && (r_op_q != MULT);
    assign bus.mult_div_sel = ((r_state == RUN) || (r_state == WRITE)) && (r_op_q != MULT);
    assign bus.hilo_write   = (r_state == WRITE);
    assign bus.done         = (r_state == DONE);
    assign bus.exc_div0     = (r_state == EXC);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench: stimulus queues per-cycle expected output vectors, a monitor compares them.
module tb_muldiv_sequencer;

    localparam int MC = 32;
    localparam int DC = 32;
    localparam int ML = 2;

    // bit positions in the packed output vector
    localparam int B_BUSY = 12, B_MRD = 11, B_ASEL = 10, B_AUXA = 9, B_AUXB = 8;
    localparam int B_MA = 7, B_MB = 6, B_MUL = 5, B_DIV = 4, B_MDS = 3;
    localparam int B_HILO = 2, B_DONE = 1, B_EXC = 0;

    localparam logic [12:0] ALL    = 13'b1_1111_1111_1111;
    localparam logic [12:0] NO_MDS = 13'b1_1111_1111_0111;

    typedef struct {
        int          cyc;
        logic [12:0] exp;
        logic [12:0] mask;
        int          tag;
    } entry_t;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    entry_t sb[$];

    muldiv_sequencer_if bus();

    muldiv_sequencer #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC),
        .MEM_LAT     (ML),
        .CNT_W       (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic add(input int c0, input int t, input int cut,
                       input logic [12:0] v, input logic [12:0] m, input int tag);
        entry_t e;
        if (cut == 0 || t < cut) begin
            e.cyc = c0 + t; e.exp = v; e.mask = m; e.tag = tag;
            sb.push_back(e);
        end
    endtask

    // Expected timeline from the accepting edge: t=1 is the first cycle after acceptance.
    task automatic push_op(input int c0, input logic [1:0] op, input int exc_t,
                           input int cut, input int tag, output int last);
        int t;
        int n;
        logic sel;
        logic isdiv;
        logic [12:0] v;
        t = 1;
        sel = (op == 2'b10);
        isdiv = (op != 2'b00);
        n = isdiv ? DC : MC;
        last = 0;
        if (sel) begin
            for (int k = 1; k <= ML; k++) begin
                v = '0; v[B_BUSY] = 1'b1; v[B_MRD] = 1'b1; v[B_AUXA] = (k == ML);
                add(c0, t, cut, v, NO_MDS, tag); t++;
            end
            for (int k = 1; k <= ML; k++) begin
                v = '0; v[B_BUSY] = 1'b1; v[B_MRD] = 1'b1; v[B_ASEL] = 1'b1; v[B_AUXB] = (k == ML);
                add(c0, t, cut, v, NO_MDS, tag); t++;
            end
        end
        v = '0; v[B_BUSY] = 1'b1; v[B_MA] = sel; v[B_MB] = sel;
        v[B_MUL] = !isdiv; v[B_DIV] = isdiv;
        add(c0, t, cut, v, NO_MDS, tag); t++;
        for (int r = 0; r < n; r++) begin
            v = '0; v[B_BUSY] = 1'b1; v[B_MA] = sel; v[B_MB] = sel; v[B_MDS] = isdiv;
            add(c0, t, cut, v, ALL, tag);
            if (isdiv && t == exc_t) begin
                t++;
                v = '0; v[B_BUSY] = 1'b1; v[B_EXC] = 1'b1;
                add(c0, t, cut, v, NO_MDS, tag); t++;
                add(c0, t, cut, '0, ALL, tag);
                last = t;
                return;
            end
            t++;
        end
        v = '0; v[B_BUSY] = 1'b1; v[B_MA] = sel; v[B_MB] = sel; v[B_MDS] = isdiv; v[B_HILO] = 1'b1;
        add(c0, t, cut, v, ALL, tag); t++;
        v = '0; v[B_BUSY] = 1'b1; v[B_DONE] = 1'b1;
        add(c0, t, cut, v, NO_MDS, tag); t++;
        add(c0, t, cut, '0, ALL, tag);
        last = t;
    endtask

    // Returns in the first IDLE cycle, so consecutive calls run back-to-back.
    task automatic run_op(input logic [1:0] op, input int exc_t, input int abort_t,
                          input bit hold, input int tag);
        int c0;
        int last;
        int stop;
        c0 = cyc;
        push_op(c0, op, exc_t, abort_t, tag, last);
        if (abort_t != 0) begin
            for (int t = abort_t; t <= abort_t + 2; t++) add(c0, t, 0, '0, ALL, tag);
            stop = abort_t + 2;
        end else begin
            stop = last;
        end
        bus.start = 1'b1;
        bus.op = op;
        while (cyc < c0 + stop) begin
            @(posedge clk); #1;
            if (!hold || cyc >= c0 + last - 1) bus.start = 1'b0;
            if (hold) bus.op = 2'b01;
            bus.div_by_zero = (exc_t != 0) && (cyc == c0 + exc_t);
            if (abort_t != 0 && cyc == c0 + abort_t) reset = 1'b0;
            if (abort_t != 0 && cyc == c0 + abort_t + 2) reset = 1'b1;
        end
    endtask

    task automatic run_reserved(input int tag);
        int c0;
        c0 = cyc;
        for (int t = 1; t <= 4; t++) add(c0, t, 0, '0, ALL, tag);
        bus.start = 1'b1;
        bus.op = 2'b11;
        while (cyc < c0 + 4) begin
            @(posedge clk); #1;
            if (cyc >= c0 + 3) bus.start = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        logic [12:0] got;
        entry_t e;
        got = {bus.busy, bus.mem_rd, bus.mem_addr_sel, bus.aux_a_write, bus.aux_b_write,
               bus.mem_a_sel, bus.mem_b_sel, bus.mult_op, bus.div_op, bus.mult_div_sel,
               bus.hilo_write, bus.done, bus.exc_div0};
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL stale_entry tag=%0d cyc=%0d expected_at=%0d", e.tag, cyc, e.cyc);
            end else if ((got & e.mask) !== (e.exp & e.mask)) begin
                errors++;
                $display("FAIL outvec tag=%0d cyc=%0d got=%b exp=%b mask=%b",
                         e.tag, cyc, got, e.exp, e.mask);
            end
        end else begin
            checks++;
            if (got !== 13'b0) begin
                errors++;
                $display("FAIL idle_outputs cyc=%0d got=%b exp=%b", cyc, got, 13'b0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        entry_t e;
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.div_by_zero = 1'b0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        run_op(2'b00, 0,  0,  1'b0, 1);   // MULT
        run_op(2'b01, 0,  0,  1'b0, 2);   // DIV 100/7
        run_op(2'b10, 0,  0,  1'b0, 3);   // DIVM
        run_op(2'b01, 10, 0,  1'b0, 4);   // DIV, divide-by-zero in cycle 10
        run_op(2'b00, 10, 0,  1'b0, 5);   // MULT ignores divide-by-zero
        run_op(2'b00, 0,  20, 1'b0, 6);   // reset in cycle 20
        run_op(2'b00, 0,  0,  1'b0, 7);   // clean run after reset
        run_op(2'b00, 0,  0,  1'b1, 8);   // start held, op changed while busy
        run_reserved(9);                  // op=11 ignored
        run_op(2'b10, 0,  0,  1'b0, 10);  // DIVM right after reserved op

        repeat (3) @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL unchecked_entry tag=%0d expected_at=%0d got=none exp=%b",
                     e.tag, e.cyc, e.exp);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the multiply and divide units and the HI/LO registers.
- Sits beside the main control unit. The control unit issues one `start` plus an opcode, then waits for `done` or `exc_div0`.
- Drives the operand-select muxes, the auxiliary operand register loads (memory-operand divide), the mult/div start pulses, and the HI/LO write.
- Removes the latency counting from the main control FSM.

Parameters:
- MULT_CYCLES, 32, RUN-state cycles for a multiply (≥1)
- DIV_CYCLES, 32, RUN-state cycles for a divide (≥1)
- MEM_LAT, 2, cycles the memory address is held per operand fetch (≥1)
- CNT_W, 6, counter width; must hold max(MULT_CYCLES, DIV_CYCLES, MEM_LAT)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request from control unit; sampled only in IDLE
- op  in  2  00=MULT, 01=DIV, 10=DIVM (operands from memory), 11=reserved
- div_by_zero  in  1  from divide unit
- busy  out  1  high in every state except IDLE
- mem_rd  out  1  holds the memory address mux on the operand address
- mem_addr_sel  out  1  0=operand address from A, 1=from B
- aux_a_write  out  1  load auxiliary operand register A from memory
- aux_b_write  out  1  load auxiliary operand register B from memory
- mem_a_sel  out  1  0=A reg, 1=aux A to the mult/div units
- mem_b_sel  out  1  0=B reg, 1=aux B to the mult/div units
- mult_op  out  1  one-cycle multiply start pulse
- div_op  out  1  one-cycle divide start pulse
- mult_div_sel  out  1  0=multiplier result, 1=divider result to HI/LO
- hilo_write  out  1  one-cycle HI/LO load enable
- done  out  1  one-cycle completion pulse
- exc_div0  out  1  one-cycle divide-by-zero exception pulse

Behaviour:
- All outputs are Moore, decoded from registered state, op_q and count. No combinational input-to-output path.
- Reset (reset=0, async): state=IDLE, count=0, op_q=MULT. Every output is 0.
- Reset mid-operation aborts immediately. No hilo_write is issued.

States and transitions:
- IDLE
  - start=1, op=MULT/DIV → START; op latched into op_q.
  - start=1, op=DIVM → FETCH_A; count=MEM_LAT-1.
  - op=11 is ignored: stay IDLE, no outputs.
  - start while busy has no effect.
- FETCH_A: mem_rd=1, mem_addr_sel=0.
  - count decrements each cycle.
  - When count==0: aux_a_write=1 → FETCH_B; count reloads to MEM_LAT-1.
- FETCH_B: mem_rd=1, mem_addr_sel=1.
  - When count==0: aux_b_write=1 → START.
- START: exactly one cycle.
  - mult_op=1 for MULT; div_op=1 for DIV/DIVM.
  - count loads MULT_CYCLES-1 or DIV_CYCLES-1 → RUN.
- RUN: count decrements each cycle.
  - Divide only: div_by_zero=1 in any RUN cycle → EXC. This has priority over count==0.
  - count==0 → WRITE.
  - div_by_zero is ignored for MULT.
- WRITE: hilo_write=1, mult_div_sel=(op_q≠MULT) → DONE.
- DONE: done=1 → IDLE.
- EXC: exc_div0=1, no hilo_write → IDLE.

Output holds and validity:
- mem_a_sel and mem_b_sel equal 1 in START, RUN and WRITE when op_q=DIVM; otherwise 0.
- mult_div_sel is valid in RUN and WRITE; it is 0 in IDLE.
- busy=1 from the cycle after start is accepted through DONE/EXC inclusive.

Latency from the accepting edge (cycle 0):
- MULT/DIV: START=1, RUN=2..N+1, WRITE=N+2, DONE=N+3.
- DIVM adds 2×MEM_LAT cycles before START.

Counter rules:
- The counter never wraps: loads always precede decrements, and it stops at 0.
- Back-to-back: start asserted in the first IDLE cycle after DONE is accepted, giving a one-cycle gap.

Decomposition:
- Package muldiv_pkg:
  - op encodings MULT/DIV/DIVM
  - state enum: IDLE, FETCH_A, FETCH_B, START, RUN, WRITE, DONE, EXC
  - default latency constants
- Sub-module cycle_counter:
  - CNT_W-bit loadable down-counter with load, dec and zero flag, async active-low reset.
  - Used for both memory-wait and RUN counting.

Test Plan:
- MULT, defaults, start at cycle 0 → mult_op=1 @1; hilo_write=1, mult_div_sel=0 @34; done @35; busy 1..35.
- DIV, operands 100/7 → div_op @1; hilo_write, mult_div_sel=1 @34; done @35; mem_a_sel=mem_b_sel=0 throughout.
- DIVM, MEM_LAT=2 → mem_addr_sel=0 @1–2 with aux_a_write @2; mem_addr_sel=1 @3–4 with aux_b_write @4; div_op @5; mem_a/b_sel=1 @5–38; hilo_write @38; done @39.
- DIV, div_by_zero raised @10 → exc_div0 @11, no hilo_write ever, IDLE @12. Repeat for MULT with div_by_zero=1 → normal completion.
- reset low @20 during MULT → all outputs 0 immediately. After release, start accepted normally, with no stale hilo_write.
- start held high during busy, plus op=11 in IDLE → exactly one operation per accepted start; op=11 yields busy=0 and no pulses.
